// File: rtl/iicmb_seq_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : iicmb_seq_pkg
//  Purpose  : Register map, command codes and status encodings shared by the
//             IICMB Wishbone sequencer and its transfer engine.
//  Revision : 1.0 - initial release
// ============================================================================
package iicmb_seq_pkg;

    typedef enum logic [1:0] {
        c_reg_csr  = 2'd0,
        c_reg_dpr  = 2'd1,
        c_reg_cmdr = 2'd2,
        c_reg_fsmr = 2'd3
    } iicmb_reg_e;

    localparam logic [2:0] c_cmd_write    = 3'b001;
    localparam logic [2:0] c_cmd_read_nak = 3'b011;
    localparam logic [2:0] c_cmd_start    = 3'b100;
    localparam logic [2:0] c_cmd_stop     = 3'b101;
    localparam logic [2:0] c_cmd_set_bus  = 3'b110;

    localparam int c_cmdr_err = 4;
    localparam int c_cmdr_al  = 5;
    localparam int c_cmdr_nak = 6;
    localparam int c_cmdr_don = 7;

    typedef enum logic [2:0] {
        c_rsp_ok       = 3'd0,
        c_rsp_nak      = 3'd1,
        c_rsp_arb_lost = 3'd2,
        c_rsp_core_err = 3'd3,
        c_rsp_timeout  = 3'd4
    } rsp_status_e;

    localparam logic [7:0] c_csr_enable = 8'hC0;

endpackage
`default_nettype wire

// File: rtl/iicmb_wb_sequencer_wb_master_xfer.sv
`default_nettype none
// ============================================================================
//  Module   : wb_master_xfer
//  Purpose  : Single-transfer Wishbone master; one start -> one bus cycle ->
//             one done pulse on the cycle after the ack.
//  Revision : 1.0 - initial release
// ============================================================================
module wb_master_xfer #(
    parameter int ADDR_WIDTH = 2,
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_start,
    input  logic                  i_we,
    input  logic [ADDR_WIDTH-1:0] i_adr,
    input  logic [DATA_WIDTH-1:0] i_wdat,
    output logic                  o_done,
    output logic [DATA_WIDTH-1:0] o_rdat,
    output logic                  o_cyc,
    output logic                  o_stb,
    output logic                  o_we,
    output logic [ADDR_WIDTH-1:0] o_adr,
    output logic [DATA_WIDTH-1:0] o_dat,
    input  logic [DATA_WIDTH-1:0] i_dat,
    input  logic                  i_ack
);

    logic                  r_cyc_q,  w_cyc_d;
    logic                  r_we_q,   w_we_d;
    logic [ADDR_WIDTH-1:0] r_adr_q,  w_adr_d;
    logic [DATA_WIDTH-1:0] r_dat_q,  w_dat_d;
    logic                  r_done_q, w_done_d;
    logic [DATA_WIDTH-1:0] r_rdat_q, w_rdat_d;

    // An ack seen while idle is ignored; start is ignored while a cycle is open.
    always_comb begin
        w_cyc_d  = r_cyc_q;
        w_we_d   = r_we_q;
        w_adr_d  = r_adr_q;
        w_dat_d  = r_dat_q;
        w_done_d = 1'b0;
        w_rdat_d = r_rdat_q;
        if (r_cyc_q) begin
            if (i_ack) begin
                w_cyc_d  = 1'b0;
                w_we_d   = 1'b0;
                w_adr_d  = '0;
                w_dat_d  = '0;
                w_done_d = 1'b1;
                w_rdat_d = i_dat;
            end
        end else if (i_start) begin
            w_cyc_d = 1'b1;
            w_we_d  = i_we;
            w_adr_d = i_adr;
            w_dat_d = i_we ? i_wdat : '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cyc_q  <= 1'b0;
            r_we_q   <= 1'b0;
            r_adr_q  <= '0;
            r_dat_q  <= '0;
            r_done_q <= 1'b0;
            r_rdat_q <= '0;
        end else begin
            r_cyc_q  <= w_cyc_d;
            r_we_q   <= w_we_d;
            r_adr_q  <= w_adr_d;
            r_dat_q  <= w_dat_d;
            r_done_q <= w_done_d;
            r_rdat_q <= w_rdat_d;
        end
    end

    assign o_cyc  = r_cyc_q;
    assign o_stb  = r_cyc_q;
    assign o_we   = r_we_q;
    assign o_adr  = r_adr_q;
    assign o_dat  = r_dat_q;
    assign o_done = r_done_q;
    assign o_rdat = r_rdat_q;

endmodule
`default_nettype wire

// File: rtl/iicmb_wb_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : iicmb_wb_sequencer
//  Purpose  : Expands single-byte I2C read/write requests into the IICMB
//             register sequence (SetBus, Start, addr, data, Stop).
//  Revision : 1.0 - initial release
// ============================================================================
module iicmb_wb_sequencer
    import iicmb_seq_pkg::*;
#(
    parameter int ADDR_WIDTH     = 2,
    parameter int DATA_WIDTH     = 8,
    parameter int BUS_ID_WIDTH   = 4,
    parameter int I2C_ADDR_WIDTH = 7,
    parameter int TIMEOUT_CYCLES = 65535
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      req_valid_i,
    output logic                      req_ready_o,
    input  logic                      req_op_i,
    input  logic [BUS_ID_WIDTH-1:0]   req_bus_i,
    input  logic [I2C_ADDR_WIDTH-1:0] req_addr_i,
    input  logic [DATA_WIDTH-1:0]     req_data_i,
    output logic                      rsp_valid_o,
    output logic [DATA_WIDTH-1:0]     rsp_data_o,
    output logic [2:0]                rsp_status_o,
    output logic                      cyc_o,
    output logic                      stb_o,
    output logic                      we_o,
    output logic [ADDR_WIDTH-1:0]     adr_o,
    output logic [DATA_WIDTH-1:0]     dat_o,
    input  logic [DATA_WIDTH-1:0]     dat_i,
    input  logic                      ack_i,
    input  logic                      irq_i
);

    localparam int                 c_tmo_w    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [c_tmo_w-1:0] c_tmo_last = c_tmo_w'(TIMEOUT_CYCLES - 1);

    localparam logic [3:0] c_st_en_csr   = 4'd0;
    localparam logic [3:0] c_st_idle     = 4'd1;
    localparam logic [3:0] c_st_bus_dpr  = 4'd2;
    localparam logic [3:0] c_st_setbus   = 4'd3;
    localparam logic [3:0] c_st_start    = 4'd4;
    localparam logic [3:0] c_st_addr_dpr = 4'd5;
    localparam logic [3:0] c_st_addr_wr  = 4'd6;
    localparam logic [3:0] c_st_data_dpr = 4'd7;
    localparam logic [3:0] c_st_data_wr  = 4'd8;
    localparam logic [3:0] c_st_rd_cmd   = 4'd9;
    localparam logic [3:0] c_st_rd_dpr   = 4'd10;
    localparam logic [3:0] c_st_stop     = 4'd11;
    localparam logic [3:0] c_st_resp     = 4'd12;

    // Sub-steps within a state: register access, then (commands only) irq wait and CMDR readback.
    localparam logic [2:0] c_ph_issue    = 3'd0;
    localparam logic [2:0] c_ph_busy     = 3'd1;
    localparam logic [2:0] c_ph_irq      = 3'd2;
    localparam logic [2:0] c_ph_rd_issue = 3'd3;
    localparam logic [2:0] c_ph_rd_busy  = 3'd4;

    function automatic logic is_cmd_state(input logic [3:0] st);
        return st inside {c_st_setbus, c_st_start, c_st_addr_wr,
                          c_st_data_wr, c_st_rd_cmd, c_st_stop};
    endfunction

    function automatic logic [2:0] cmd_code(input logic [3:0] st);
        logic [2:0] code;
        case (st)
            c_st_setbus: code = c_cmd_set_bus;
            c_st_start:  code = c_cmd_start;
            c_st_rd_cmd: code = c_cmd_read_nak;
            c_st_stop:   code = c_cmd_stop;
            default:     code = c_cmd_write;
        endcase
        return code;
    endfunction

    logic [3:0]                r_state_q,  w_state_d;
    logic [2:0]                r_phase_q,  w_phase_d;
    logic [c_tmo_w-1:0]        r_tmo_q,    w_tmo_d;
    logic                      r_op_q,     w_op_d;
    logic [BUS_ID_WIDTH-1:0]   r_bus_q,    w_bus_d;
    logic [I2C_ADDR_WIDTH-1:0] r_addr_q,   w_addr_d;
    logic [DATA_WIDTH-1:0]     r_data_q,   w_data_d;
    logic [DATA_WIDTH-1:0]     r_rdata_q,  w_rdata_d;
    rsp_status_e               r_status_q, w_status_d;

    logic                  w_start;
    logic                  w_we;
    iicmb_reg_e            w_adr;
    logic [DATA_WIDTH-1:0] w_wdat;
    logic                  w_xfer_done;
    logic [DATA_WIDTH-1:0] w_xfer_rdat;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state_q  <= c_st_en_csr;
            r_phase_q  <= c_ph_issue;
            r_tmo_q    <= '0;
            r_op_q     <= 1'b0;
            r_bus_q    <= '0;
            r_addr_q   <= '0;
            r_data_q   <= '0;
            r_rdata_q  <= '0;
            r_status_q <= c_rsp_ok;
        end else begin
            r_state_q  <= w_state_d;
            r_phase_q  <= w_phase_d;
            r_tmo_q    <= w_tmo_d;
            r_op_q     <= w_op_d;
            r_bus_q    <= w_bus_d;
            r_addr_q   <= w_addr_d;
            r_data_q   <= w_data_d;
            r_rdata_q  <= w_rdata_d;
            r_status_q <= w_status_d;
        end
    end

    always_comb begin
        w_state_d  = r_state_q;
        w_phase_d  = r_phase_q;
        w_tmo_d    = r_tmo_q;
        w_op_d     = r_op_q;
        w_bus_d    = r_bus_q;
        w_addr_d   = r_addr_q;
        w_data_d   = r_data_q;
        w_rdata_d  = r_rdata_q;
        w_status_d = r_status_q;
        case (r_state_q)
            c_st_idle: begin
                if (req_valid_i) begin
                    w_op_d     = req_op_i;
                    w_bus_d    = req_bus_i;
                    w_addr_d   = req_addr_i;
                    w_data_d   = req_data_i;
                    w_rdata_d  = '0;
                    w_status_d = c_rsp_ok;
                    w_state_d  = c_st_bus_dpr;
                    w_phase_d  = c_ph_issue;
                end
            end
            c_st_resp: w_state_d = c_st_idle;
            default: begin
                case (r_phase_q)
                    c_ph_issue: begin
                        w_phase_d = c_ph_busy;
                        w_tmo_d   = '0;
                    end
                    c_ph_busy: begin
                        // Timeout window starts at the CMDR write, so count while it is on the bus.
                        if (r_tmo_q != c_tmo_last) w_tmo_d = r_tmo_q + c_tmo_w'(1);
                        if (w_xfer_done) begin
                            if (is_cmd_state(r_state_q)) begin
                                w_phase_d = c_ph_irq;
                            end else begin
                                w_phase_d = c_ph_issue;
                                case (r_state_q)
                                    c_st_en_csr:   w_state_d = c_st_idle;
                                    c_st_bus_dpr:  w_state_d = c_st_setbus;
                                    c_st_addr_dpr: w_state_d = c_st_addr_wr;
                                    c_st_data_dpr: w_state_d = c_st_data_wr;
                                    default: begin
                                        w_state_d = c_st_stop;
                                        w_rdata_d = w_xfer_rdat;
                                    end
                                endcase
                            end
                        end
                    end
                    c_ph_irq: begin
                        if (irq_i) begin
                            w_phase_d = c_ph_rd_issue;
                        end else if (r_tmo_q == c_tmo_last) begin
                            w_state_d  = c_st_resp;
                            w_phase_d  = c_ph_issue;
                            w_status_d = c_rsp_timeout;
                            w_rdata_d  = '0;
                        end else begin
                            w_tmo_d = r_tmo_q + c_tmo_w'(1);
                        end
                    end
                    c_ph_rd_issue: w_phase_d = c_ph_rd_busy;
                    c_ph_rd_busy: begin
                        if (w_xfer_done) begin
                            w_phase_d = c_ph_issue;
                            if (w_xfer_rdat[c_cmdr_err]) begin
                                w_state_d  = c_st_resp;
                                w_status_d = c_rsp_core_err;
                                w_rdata_d  = '0;
                            end else if (w_xfer_rdat[c_cmdr_al]) begin
                                w_state_d  = c_st_resp;
                                w_status_d = c_rsp_arb_lost;
                                w_rdata_d  = '0;
                            end else if (w_xfer_rdat[c_cmdr_nak]) begin
                                if (r_status_q == c_rsp_ok) w_status_d = c_rsp_nak;
                                w_rdata_d = '0;
                                w_state_d = (r_state_q == c_st_stop) ? c_st_resp : c_st_stop;
                            end else begin
                                case (r_state_q)
                                    c_st_setbus:  w_state_d = c_st_start;
                                    c_st_start:   w_state_d = c_st_addr_dpr;
                                    c_st_addr_wr: w_state_d = r_op_q ? c_st_rd_cmd : c_st_data_dpr;
                                    c_st_data_wr: w_state_d = c_st_stop;
                                    c_st_rd_cmd:  w_state_d = c_st_rd_dpr;
                                    default:      w_state_d = c_st_resp;
                                endcase
                            end
                        end
                    end
                    default: w_phase_d = c_ph_issue;
                endcase
            end
        endcase
    end

    always_comb begin
        w_we         = 1'b0;
        w_adr        = c_reg_csr;
        w_wdat       = '0;
        w_start      = (r_phase_q == c_ph_issue || r_phase_q == c_ph_rd_issue) &&
                       (r_state_q != c_st_idle) && (r_state_q != c_st_resp);
        req_ready_o  = (r_state_q == c_st_idle);
        rsp_valid_o  = (r_state_q == c_st_resp);
        rsp_status_o = rsp_valid_o ? r_status_q : c_rsp_ok;
        rsp_data_o   = (rsp_valid_o && r_status_q == c_rsp_ok) ? r_rdata_q : '0;
        case (r_state_q)
            c_st_en_csr: begin
                w_we   = 1'b1;
                w_adr  = c_reg_csr;
                w_wdat = DATA_WIDTH'(c_csr_enable);
            end
            c_st_bus_dpr: begin
                w_we   = 1'b1;
                w_adr  = c_reg_dpr;
                w_wdat = DATA_WIDTH'(r_bus_q);
            end
            c_st_addr_dpr: begin
                w_we   = 1'b1;
                w_adr  = c_reg_dpr;
                w_wdat = DATA_WIDTH'({r_addr_q, r_op_q});
            end
            c_st_data_dpr: begin
                w_we   = 1'b1;
                w_adr  = c_reg_dpr;
                w_wdat = r_data_q;
            end
            c_st_rd_dpr: begin
                w_adr = c_reg_dpr;
            end
            default: begin
                w_adr = c_reg_cmdr;
                if (r_phase_q == c_ph_issue || r_phase_q == c_ph_busy) begin
                    w_we   = 1'b1;
                    w_wdat = DATA_WIDTH'(cmd_code(r_state_q));
                end
            end
        endcase
    end

    wb_master_xfer #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_xfer (
        .clk     (clk_i),
        .rst     (rst_i),
        .i_start (w_start),
        .i_we    (w_we),
        .i_adr   (ADDR_WIDTH'(w_adr)),
        .i_wdat  (w_wdat),
        .o_done  (w_xfer_done),
        .o_rdat  (w_xfer_rdat),
        .o_cyc   (cyc_o),
        .o_stb   (stb_o),
        .o_we    (we_o),
        .o_adr   (adr_o),
        .o_dat   (dat_o),
        .i_dat   (dat_i),
        .i_ack   (ack_i)
    );

endmodule
`default_nettype wire

// File: tb/tb_iicmb_wb_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_iicmb_wb_sequencer
//  Purpose  : Self-checking bench with a behavioural IICMB register slave.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_iicmb_wb_sequencer;

    typedef logic [10:0] ent_t;  // {we, adr[1:0], dat[7:0]}

    typedef struct {
        logic       op;
        logic [3:0] bus;
        logic [6:0] addr;
        logic [7:0] data;
        logic       nak;
        logic [7:0] rd_byte;
        logic [2:0] exp_status;
        logic [7:0] exp_data;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst_i;
    logic       req_valid_i;
    logic       req_ready_o;
    logic       req_op_i;
    logic [3:0] req_bus_i;
    logic [6:0] req_addr_i;
    logic [7:0] req_data_i;
    logic       rsp_valid_o;
    logic [7:0] rsp_data_o;
    logic [2:0] rsp_status_o;
    logic       cyc_o, stb_o, we_o;
    logic [1:0] adr_o;
    logic [7:0] dat_o;
    logic [7:0] dat_i;
    logic       ack_i;
    logic       irq_i;

    int   checks = 0;
    int   errors = 0;
    int   cycles = 0;
    ent_t log_q[$];
    ent_t exp_q[$];
    vec_t vecs[6];

    logic       cfg_nak_addr  = 1'b0;
    logic       cfg_hang_start = 1'b0;
    logic       cfg_al_start  = 1'b0;
    logic [7:0] cfg_rd_byte   = 8'h00;
    logic [7:0] cmdr_val      = 8'h80;
    int         write_cnt     = 0;
    int         irq_cnt       = 0;
    int         t_start_ack   = 0;

    iicmb_wb_sequencer #(.TIMEOUT_CYCLES(16)) dut (
        .clk_i        (clk),
        .rst_i        (rst_i),
        .req_valid_i  (req_valid_i),
        .req_ready_o  (req_ready_o),
        .req_op_i     (req_op_i),
        .req_bus_i    (req_bus_i),
        .req_addr_i   (req_addr_i),
        .req_data_i   (req_data_i),
        .rsp_valid_o  (rsp_valid_o),
        .rsp_data_o   (rsp_data_o),
        .rsp_status_o (rsp_status_o),
        .cyc_o        (cyc_o),
        .stb_o        (stb_o),
        .we_o         (we_o),
        .adr_o        (adr_o),
        .dat_o        (dat_o),
        .dat_i        (dat_i),
        .ack_i        (ack_i),
        .irq_i        (irq_i)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cycles <= cycles + 1;

    // IICMB register slave: one-cycle ack, irq a few cycles after each CMDR write.
    initial begin
        ack_i = 1'b0;
        irq_i = 1'b0;
        dat_i = 8'h00;
        forever begin
            @(negedge clk);
            if (rst_i) begin
                ack_i   = 1'b0;
                irq_i   = 1'b0;
                irq_cnt = 0;
            end else begin
                if (irq_cnt > 0) begin
                    irq_cnt--;
                    if (irq_cnt == 0) irq_i = 1'b1;
                end
                if (ack_i) begin
                    ack_i = 1'b0;
                end else if (cyc_o && stb_o) begin
                    ack_i = 1'b1;
                    if (we_o) begin
                        log_q.push_back({1'b1, adr_o, dat_o});
                        if (adr_o == 2'd2) begin
                            cmdr_val = 8'h80;
                            if (dat_o[2:0] == 3'b100) begin
                                write_cnt   = 0;
                                t_start_ack = cycles;
                                if (cfg_al_start) cmdr_val = 8'h20;
                            end else if (dat_o[2:0] == 3'b001) begin
                                if (cfg_nak_addr && write_cnt == 0) cmdr_val = 8'h40;
                                write_cnt++;
                            end
                            if (!(dat_o[2:0] == 3'b100 && cfg_hang_start)) irq_cnt = 3;
                        end
                    end else begin
                        log_q.push_back({1'b0, adr_o, 8'h00});
                        if (adr_o == 2'd2) begin
                            dat_i = cmdr_val;
                            irq_i = 1'b0;
                        end else begin
                            dat_i = cfg_rd_byte;
                        end
                    end
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_log(input string name);
        int bad = -1;
        int n   = (log_q.size() < exp_q.size()) ? log_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) begin
            if (bad < 0 && log_q[i] !== exp_q[i]) bad = i;
        end
        checks++;
        if (bad >= 0 || log_q.size() != exp_q.size()) begin
            errors++;
            if (bad >= 0)
                $display("FAIL %s: entry %0d got %03h expected %03h", name, bad, log_q[bad], exp_q[bad]);
            else
                $display("FAIL %s: %0d transfers, expected %0d", name, log_q.size(), exp_q.size());
        end
    endtask

    task automatic push_exp(input logic we, input logic [1:0] adr, input logic [7:0] dat);
        exp_q.push_back({we, adr, dat});
    endtask

    task automatic build_exp(input vec_t v);
        exp_q.delete();
        push_exp(1, 2'd1, {4'b0, v.bus});
        push_exp(1, 2'd2, 8'h06); push_exp(0, 2'd2, 8'h00);
        push_exp(1, 2'd2, 8'h04); push_exp(0, 2'd2, 8'h00);
        push_exp(1, 2'd1, {v.addr, v.op});
        push_exp(1, 2'd2, 8'h01); push_exp(0, 2'd2, 8'h00);
        if (!v.nak && !v.op) begin
            push_exp(1, 2'd1, v.data);
            push_exp(1, 2'd2, 8'h01); push_exp(0, 2'd2, 8'h00);
        end else if (!v.nak) begin
            push_exp(1, 2'd2, 8'h03); push_exp(0, 2'd2, 8'h00);
            push_exp(0, 2'd1, 8'h00);
        end
        push_exp(1, 2'd2, 8'h05); push_exp(0, 2'd2, 8'h00);
    endtask

    task automatic wait_ready(input string name);
        bit ok = 0;
        for (int i = 0; i < 500; i++) begin
            @(negedge clk);
            if (req_ready_o) begin
                ok = 1;
                break;
            end
        end
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s: req_ready_o stayed 0, expected 1 within 500 cycles", name);
        end
    endtask

    task automatic run_req(input string name, input vec_t v,
                           output logic [2:0] st, output logic [7:0] d, output int t_rsp);
        bit got = 0;
        st = 3'd7; d = 8'hXX; t_rsp = 0;
        wait_ready({name, "_ready"});
        log_q.delete();
        req_valid_i = 1'b1;
        req_op_i    = v.op;
        req_bus_i   = v.bus;
        req_addr_i  = v.addr;
        req_data_i  = v.data;
        @(negedge clk);
        req_valid_i = 1'b0;
        chk({name, "_busy_ready"}, req_ready_o, 0);
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (rsp_valid_o) begin
                got   = 1;
                st    = rsp_status_o;
                d     = rsp_data_o;
                t_rsp = cycles;
                break;
            end
        end
        chk({name, "_rsp_seen"}, got, 1);
        @(negedge clk);
        chk({name, "_rsp_one_cycle"}, rsp_valid_o, 0);
    endtask

    initial begin
        logic [2:0] st;
        logic [7:0] d;
        int         t_rsp;
        int         seen;
        vec_t       v;

        // Fields: op, bus, addr, data, nak, rd_byte, exp_status, exp_data
        vecs[0] = '{1'b0, 4'h0, 7'h22, 8'h2A, 1'b0, 8'h00, 3'd0, 8'h00};
        vecs[1] = '{1'b1, 4'h0, 7'h22, 8'h00, 1'b0, 8'd100, 3'd0, 8'd100};
        vecs[2] = '{1'b0, 4'h1, 7'h22, 8'h55, 1'b1, 8'h00, 3'd1, 8'h00};
        vecs[3] = '{1'b1, 4'h3, 7'h7F, 8'h00, 1'b0, 8'hA5, 3'd0, 8'hA5};
        vecs[4] = '{1'b1, 4'h5, 7'h11, 8'h00, 1'b1, 8'h77, 3'd1, 8'h00};
        vecs[5] = '{1'b0, 4'hF, 7'h00, 8'hFF, 1'b0, 8'h00, 3'd0, 8'h00};

        rst_i = 1'b1; req_valid_i = 1'b0; req_op_i = 1'b0;
        req_bus_i = '0; req_addr_i = '0; req_data_i = '0;
        repeat (3) @(negedge clk);
        chk("rst_cyc", cyc_o, 0);
        chk("rst_stb", stb_o, 0);
        chk("rst_ready", req_ready_o, 0);
        chk("rst_rsp_valid", rsp_valid_o, 0);
        rst_i = 1'b0;

        seen = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (stb_o) begin
                seen = 1;
                break;
            end
        end
        chk("first_stb_seen", seen, 1);
        chk("first_xfer", {we_o, adr_o, dat_o}, {1'b1, 2'd0, 8'hC0});
        chk("ready_during_enable", req_ready_o, 0);
        wait_ready("enable_done");
        exp_q.delete();
        push_exp(1, 2'd0, 8'hC0);
        chk_log("enable_log");

        for (int i = 0; i < 6; i++) begin
            v = vecs[i];
            cfg_nak_addr = v.nak;
            cfg_rd_byte  = v.rd_byte;
            build_exp(v);
            run_req($sformatf("vec%0d", i), v, st, d, t_rsp);
            chk($sformatf("vec%0d_status", i), st, v.exp_status);
            chk($sformatf("vec%0d_data", i), d, v.exp_data);
            chk_log($sformatf("vec%0d_log", i));
        end
        cfg_nak_addr = 1'b0;

        // irq never arrives after Start: timeout, no Stop.
        cfg_hang_start = 1'b1;
        v = '{1'b0, 4'h2, 7'h22, 8'h2A, 1'b0, 8'h00, 3'd4, 8'h00};
        run_req("tmo", v, st, d, t_rsp);
        chk("tmo_status", st, 3'd4);
        chk("tmo_data", d, 0);
        chk("tmo_delay", t_rsp - t_start_ack, 16);
        exp_q.delete();
        push_exp(1, 2'd1, 8'h02);
        push_exp(1, 2'd2, 8'h06); push_exp(0, 2'd2, 8'h00);
        push_exp(1, 2'd2, 8'h04);
        chk_log("tmo_log");
        cfg_hang_start = 1'b0;

        // Arbitration lost on Start: straight to response, no Stop.
        cfg_al_start = 1'b1;
        v = '{1'b1, 4'h1, 7'h33, 8'h00, 1'b0, 8'h99, 3'd2, 8'h00};
        cfg_rd_byte = 8'h99;
        run_req("al", v, st, d, t_rsp);
        chk("al_status", st, 3'd2);
        chk("al_data", d, 0);
        exp_q.delete();
        push_exp(1, 2'd1, 8'h01);
        push_exp(1, 2'd2, 8'h06); push_exp(0, 2'd2, 8'h00);
        push_exp(1, 2'd2, 8'h04); push_exp(0, 2'd2, 8'h00);
        chk_log("al_log");
        cfg_al_start = 1'b0;

        // Reset while a strobe is active mid-sequence.
        wait_ready("mid_rst_ready");
        log_q.delete();
        req_valid_i = 1'b1; req_op_i = 1'b0; req_bus_i = 4'h0;
        req_addr_i = 7'h22; req_data_i = 8'h2A;
        @(negedge clk);
        req_valid_i = 1'b0;
        seen = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (stb_o && log_q.size() >= 3) begin
                seen = 1;
                break;
            end
        end
        chk("mid_rst_stb_seen", seen, 1);
        rst_i = 1'b1;
        @(negedge clk);
        chk("mid_rst_cyc", cyc_o, 0);
        chk("mid_rst_stb", stb_o, 0);
        chk("mid_rst_rsp", rsp_valid_o, 0);
        rst_i = 1'b0;
        log_q.delete();
        seen = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (rsp_valid_o) seen++;
            if (req_ready_o) break;
        end
        chk("mid_rst_ready", req_ready_o, 1);
        chk("mid_rst_no_rsp", seen, 0);
        exp_q.delete();
        push_exp(1, 2'd0, 8'hC0);
        chk_log("mid_rst_log");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
`default_nettype wire

// File: doc/iicmb_wb_sequencer.md
Name: iicmb_wb_sequencer

Overview:
Synthesizable Wishbone master sitting directly upstream of the IICMB I2C controller, in place of the bench's procedural write/read tasks. It accepts single-byte I2C read/write requests on a valid/ready port and expands each one into the IICMB register sequence: Set Bus, Start, address Write, data Write or Read, then Stop. It returns read data and a completion status. On leaving reset it enables the core once.

Parameters:
ADDR_WIDTH, 2, Wishbone address width (IICMB register select)
DATA_WIDTH, 8, Wishbone data width
BUS_ID_WIDTH, 4, width of I2C bus selector; zero-extended into DPR
I2C_ADDR_WIDTH, 7, I2C slave address width
TIMEOUT_CYCLES, 65535, max clk_i cycles waiting for irq_i per command

Ports:
clk_i  in  1  system clock
rst_i  in  1  synchronous, active-high reset
req_valid_i  in  1  request present
req_ready_o  out  1  sequencer idle; request accepted when valid&ready
req_op_i  in  1  0=write, 1=read
req_bus_i  in  BUS_ID_WIDTH  target I2C bus id
req_addr_i  in  I2C_ADDR_WIDTH  slave address
req_data_i  in  DATA_WIDTH  write byte (ignored for read)
rsp_valid_o  out  1  one-cycle completion pulse
rsp_data_o  out  DATA_WIDTH  read byte; 0 for writes and for failed reads
rsp_status_o  out  3  OK=0, NAK=1, ARB_LOST=2, CORE_ERR=3, TIMEOUT=4
cyc_o  out  1  Wishbone cycle
stb_o  out  1  Wishbone strobe
we_o  out  1  Wishbone write enable
adr_o  out  ADDR_WIDTH  register: CSR=0, DPR=1, CMDR=2, FSMR=3
dat_o  out  DATA_WIDTH  write data
dat_i  in  DATA_WIDTH  read data
ack_i  in  1  Wishbone acknowledge
irq_i  in  1  IICMB interrupt, level

Behaviour:
- Reset: all outputs 0 and FSM in EN_CSR. Reset mid-operation drops cyc_o/stb_o at the next edge, emits no response, and re-runs the enable write.
- Wishbone transfer: cyc_o, stb_o, we_o, adr_o and dat_o are driven from the cycle after the engine is started. They are held until ack_i is sampled high, then cleared on the following edge. There is at least one idle cycle between transfers. Read data is captured on the ack cycle.
- Command step: write CMDR with the command code, then wait for irq_i=1, then read CMDR (which clears the irq).
- Status decode on the CMDR read, with priority ERR(bit4) > AL(bit5) > NAK(bit6) > DON(bit7).
- Command codes: Write=001, ReadNak=011, Start=100, Stop=101, SetBus=110.
- FSM: EN_CSR (write CSR 0xC0) -> IDLE.
  - IDLE: req_ready_o=1; latch the request on accept.
  - BUS_DPR (DPR <= bus id) -> SETBUS -> START -> ADDR_DPR (DPR <= {addr, op}) -> ADDR_WR.
  - Write path: DATA_DPR (DPR <= data) -> DATA_WR -> STOP.
  - Read path: RD_CMD (ReadNak) -> RD_DPR (read DPR into rsp_data) -> STOP.
  - STOP -> RESP (rsp_valid_o=1 for one cycle) -> IDLE.
- Error handling:
  - NAK on ADDR_WR or DATA_WR: skip remaining data steps, go to STOP, status NAK.
  - AL or ERR on any step: no Stop, go straight to RESP with ARB_LOST or CORE_ERR.
  - Timeout: the counter resets at each CMDR write. When it reaches TIMEOUT_CYCLES without irq_i, go to RESP with TIMEOUT and no Stop.
- Status precedence: a status recorded before STOP is reported even if the Stop itself completes DON.
- Requests are not queued; req_ready_o=0 outside IDLE. req_valid_i arriving in the same cycle that RESP pulses is accepted on the next cycle.
- ack_i arriving while no strobe is active is ignored.

Decomposition:
- Package iicmb_seq_pkg:
  - register enum (CSR/DPR/CMDR/FSMR)
  - command code constants
  - CMDR bit positions
  - rsp status enum
  - CSR enable constant 0xC0
- Sub-module wb_master_xfer: single-transfer Wishbone engine.
  - Inputs: start, we, adr, wdat.
  - Outputs: done pulse, rdat.
  - Owns cyc/stb/ack timing.
  - The sequencer FSM instantiates it once.

Test Plan:
- Release reset, slave acks in 1 cycle -> first transfer is a write of adr 0, data 0xC0; req_ready_o rises only after it completes.
- Write bus 0, addr 0x22, data 0x2A with a normal slave -> WB writes in this order:
  - DPR 0x00, CMDR 0x06, CMDR read;
  - CMDR 0x04, CMDR read;
  - DPR 0x44, CMDR 0x01, CMDR read;
  - DPR 0x2A, CMDR 0x01, CMDR read;
  - CMDR 0x05, CMDR read;
  - then rsp status OK and data 0.
- Read addr 0x22, I2C slave returns 100 -> DPR written with 0x45, CMDR written with 0x03, DPR read, rsp_data_o=100, status OK.
- Address NAK (CMDR reads 0x40 after the addr write) -> no data DPR write, Stop issued, status NAK.
- irq_i held low after Start with TIMEOUT_CYCLES=16 -> rsp status TIMEOUT 16 cycles after the CMDR write; no Stop issued.
- rst_i asserted while stb_o is high -> cyc_o/stb_o low next cycle, no rsp pulse, CSR 0xC0 rewritten.
